// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank: FSM state encoding, frame
// layout and sizing helpers.
package spi_pkg;

   // FSM states of the frame receiver.
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_SHIFT_HDR  = 2'd1,
      ST_SHIFT_DATA = 2'd2,
      ST_COMMIT     = 2'd3
   } state_t;

   // Value of the leading frame bit that marks a write.
   localparam bit RW_WRITE = 1'b1;

   // Total frame length: R/W bit, address field, data field.
   function automatic int frame_len(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

   // Position of the R/W bit in a fully received frame (MSB of the shifter).
   function automatic int rw_bit_pos(input int addr_w, input int data_w);
      return addr_w + data_w;
   endfunction

   // Counter width able to hold the saturation value flen+1.
   function automatic int cnt_width(input int flen);
      return $clog2(flen + 2);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, followed by a
// registered copy of the synchronised level for edge detection.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
   assign prev_d = sync_q[SYNC_STAGES-1];

   // Synchroniser chain and previous-level register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour, forming a true shift chain.
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave mapping a host-visible register file onto a flat
// configuration bus, with readback, write strobe and framing-error pulse.
module spi_reg_bank
   import spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int NUM_REGS    = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sclk,
   input  logic                         sdi,
   input  logic                         cs,
   output logic                         sdo,
   output logic                         sdo_en,
   output logic [NUM_REGS*DATA_W-1:0]   regs,
   output logic                         wr_stb,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         frame_err
);

   localparam int F       = frame_len(ADDR_W, DATA_W);
   localparam int HDR_LEN = 1 + ADDR_W;
   localparam int RW_POS  = rw_bit_pos(ADDR_W, DATA_W);
   localparam int CNT_W   = cnt_width(F);

   localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(F);
   localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(F + 1);
   localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_LEN - 1);

   // Synchronised SPI inputs. The chains reset low, so a cs that is already
   // low when reset releases never produces a falling edge until it has
   // first been seen high.
   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic sdi_level, sdi_rise_unused, sdi_fall_unused;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst(rst), .async_in(sclk),
      .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst(rst), .async_in(cs),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
      .clk(clk), .rst(rst), .async_in(sdi),
      .level(sdi_level), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
   );

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [F-1:0]            rx_q, rx_d;
   logic [DATA_W-1:0]       tx_q, tx_d;
   logic                    sdo_q, sdo_d;
   logic                    rd_q, rd_d;
   logic                    load_pend_q, load_pend_d;
   logic [ADDR_W-1:0]       hdr_addr_q, hdr_addr_d;
   logic                    armed_q, armed_d;
   logic                    wr_stb_q, wr_stb_d;
   logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]       regs_q [NUM_REGS];
   logic [DATA_W-1:0]       regs_d [NUM_REGS];

   // A cs rise in the same cycle as an sclk edge discards the edge.
   logic              sclk_rise_ok, sclk_fall_ok;
   logic [F-1:0]      rx_shift;
   logic              hdr_rw_new;
   logic [ADDR_W-1:0] hdr_addr_new;
   logic              com_rw;
   logic [ADDR_W-1:0] com_addr;
   logic [DATA_W-1:0] com_data;
   logic              write_ok;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] load_val;

   assign sclk_rise_ok = sclk_rise & ~cs_rise;
   assign sclk_fall_ok = sclk_fall & ~cs_rise;
   assign rx_shift     = {rx_q[F-2:0], sdi_level};
   assign hdr_rw_new   = rx_shift[ADDR_W];
   assign hdr_addr_new = rx_shift[ADDR_W-1:0];
   assign com_rw       = rx_q[RW_POS];
   assign com_addr     = rx_q[RW_POS-1 -: ADDR_W];
   assign com_data     = rx_q[DATA_W-1:0];

   assign write_ok  = (state_q == ST_COMMIT) && (cnt_q == CNT_FULL) &&
                      (com_rw == RW_WRITE) && (32'(com_addr) < 32'(NUM_REGS));
   assign frame_err = (state_q == ST_COMMIT) && (cnt_q != '0) && (cnt_q != CNT_FULL);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: cs framing dominates, header length selects the data phase.
   always_comb begin
      // NOTE: every combinationally assigned variable gets a default first,
      // so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:       if (cs_fall) state_d = ST_SHIFT_HDR;
         ST_SHIFT_HDR:  if (cs_rise) state_d = ST_COMMIT;
                        else if (sclk_rise && cnt_q == CNT_HDR_LAST) state_d = ST_SHIFT_DATA;
         ST_SHIFT_DATA: if (cs_rise) state_d = ST_COMMIT;
         ST_COMMIT:     state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   // Readback mux; out-of-range addresses read as zero.
   always_comb begin
      rd_val = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (32'(hdr_addr_q) == 32'(k)) rd_val = regs_q[k];
      end
   end

   // Output and datapath next values for shifters, counter and register file.
   always_comb begin
      cnt_d       = cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      sdo_d       = sdo_q;
      rd_d        = rd_q;
      load_pend_d = load_pend_q;
      hdr_addr_d  = hdr_addr_q;
      armed_d     = armed_q | cs_level;
      wr_stb_d    = 1'b0;
      wr_addr_d   = wr_addr_q;
      regs_d      = regs_q;
      load_val    = rd_val;

      unique case (state_q)
         ST_IDLE: begin
            sdo_d = 1'b0;
            if (cs_fall) begin
               cnt_d       = '0;
               rd_d        = 1'b0;
               load_pend_d = 1'b0;
            end
         end
         ST_SHIFT_HDR, ST_SHIFT_DATA: begin
            if (sclk_rise_ok) begin
               rx_d = rx_shift;
               if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
               if (state_q == ST_SHIFT_HDR && cnt_q == CNT_HDR_LAST) begin
                  rd_d        = (hdr_rw_new != RW_WRITE);
                  load_pend_d = (hdr_rw_new != RW_WRITE);
                  hdr_addr_d  = hdr_addr_new;
               end
            end
            if (state_q == ST_SHIFT_DATA && sclk_fall_ok && rd_q) begin
               if (load_pend_q) begin
                  sdo_d       = load_val[DATA_W-1];
                  tx_d        = load_val << 1;
                  load_pend_d = 1'b0;
               end else begin
                  sdo_d = tx_q[DATA_W-1];
                  tx_d  = tx_q << 1;
               end
            end
            if (cs_rise) sdo_d = 1'b0;
         end
         ST_COMMIT: begin
            sdo_d = 1'b0;
            if (write_ok) begin
               wr_stb_d  = 1'b1;
               wr_addr_d = com_addr;
               for (int k = 0; k < NUM_REGS; k++) begin
                  if (32'(com_addr) == 32'(k)) regs_d[k] = com_data;
               end
            end
         end
         default: sdo_d = 1'b0;
      endcase
   end

   // Datapath and register-file flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         sdo_q       <= 1'b0;
         rd_q        <= 1'b0;
         load_pend_q <= 1'b0;
         hdr_addr_q  <= '0;
         armed_q     <= 1'b0;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= '0;
         // NOTE: the register file is built from flops driving live
         // configuration, so it is reset rather than left as uninitialised RAM.
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      end else begin
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         sdo_q       <= sdo_d;
         rd_q        <= rd_d;
         load_pend_q <= load_pend_d;
         hdr_addr_q  <= hdr_addr_d;
         armed_q     <= armed_d;
         wr_stb_q    <= wr_stb_d;
         wr_addr_q   <= wr_addr_d;
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
      end
   end

   // Flatten the register file onto the output bus.
   always_comb begin
      regs = '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k*DATA_W +: DATA_W] = regs_q[k];
   end

   assign sdo     = sdo_q;
   assign sdo_en  = armed_q & ~cs_level;
   assign wr_stb  = wr_stb_q;
   assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: default geometry on instance A and a
// 3-bit-address / 16-bit-data / 8-register geometry on instance B.
module tb_spi_reg_bank;

   localparam int HALF = 80;   // sclk half period (16 clk cycles per sclk period)

   logic clk, rst, sclk, sdi, cs_a, cs_b;

   logic          sdo_a, sdo_en_a, wr_stb_a, frame_err_a;
   logic [39:0]   regs_a;
   logic [6:0]    wr_addr_a;

   logic          sdo_b, sdo_en_b, wr_stb_b, frame_err_b;
   logic [127:0]  regs_b;
   logic [2:0]    wr_addr_b;

   int vectors    = 0;
   int miscompares = 0;

   int stb_a_n = 0, ferr_a_n = 0, stb_b_n = 0, ferr_b_n = 0;

   spi_reg_bank u_dut_a (
      .clk(clk), .rst(rst), .sclk(sclk), .sdi(sdi), .cs(cs_a),
      .sdo(sdo_a), .sdo_en(sdo_en_a), .regs(regs_a), .wr_stb(wr_stb_a),
      .wr_addr(wr_addr_a), .frame_err(frame_err_a)
   );

   spi_reg_bank #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8), .SYNC_STAGES(2)) u_dut_b (
      .clk(clk), .rst(rst), .sclk(sclk), .sdi(sdi), .cs(cs_b),
      .sdo(sdo_b), .sdo_en(sdo_en_b), .regs(regs_b), .wr_stb(wr_stb_b),
      .wr_addr(wr_addr_b), .frame_err(frame_err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitors: count high cycles, sampled away from the active edge.
   always @(negedge clk) begin
      if (wr_stb_a)    stb_a_n++;
      if (frame_err_a) ferr_a_n++;
      if (wr_stb_b)    stb_b_n++;
      if (frame_err_b) ferr_b_n++;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cs_down(input bit sel_b);
      if (sel_b) cs_b = 1'b0;
      else       cs_a = 1'b0;
      #(HALF);
   endtask

   task automatic cs_up(input bit sel_b);
      #(HALF);
      if (sel_b) cs_b = 1'b1;
      else       cs_a = 1'b1;
      #(200);
   endtask

   // Mode 0: drive sdi with sclk low, sample sdo just before the rising edge.
   task automatic shift_bits(input logic [31:0] bits, input int n, input bit sel_b,
                             output logic [31:0] rx);
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         sdi = bits[i];
         #(HALF);
         rx = {rx[30:0], (sel_b ? sdo_b : sdo_a)};
         sclk = 1'b1;
         #(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input logic [31:0] bits, input int n, input bit sel_b,
                        output logic [31:0] rx);
      cs_down(sel_b);
      shift_bits(bits, n, sel_b, rx);
      cs_up(sel_b);
   endtask

   initial begin
      logic [31:0] rx;
      int s_stb, s_ferr;

      rst = 1'b1; sclk = 1'b0; sdi = 1'b0; cs_a = 1'b1; cs_b = 1'b1;
      repeat (5) @(negedge clk);

      // Reset state
      check("rst_regs_a",    regs_a, '0);
      check("rst_sdo_a",     sdo_a, 1'b0);
      check("rst_sdo_en_a",  sdo_en_a, 1'b0);
      check("rst_wr_stb_a",  wr_stb_a, 1'b0);
      check("rst_wr_addr_a", wr_addr_a, '0);
      check("rst_ferr_a",    frame_err_a, 1'b0);
      check("rst_regs_b",    regs_b, '0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_sdo_en_a", sdo_en_a, 1'b0);

      // Write reg2 = 0xA5
      s_stb = stb_a_n; s_ferr = ferr_a_n;
      cs_down(1'b0);
      check("frame_sdo_en_a", sdo_en_a, 1'b1);
      shift_bits(32'h82A5, 16, 1'b0, rx);
      cs_up(1'b0);
      check("wr2_regs",   regs_a, 40'h00_00_A5_00_00);
      check("wr2_stb",    stb_a_n - s_stb, 1);
      check("wr2_addr",   wr_addr_a, 7'd2);
      check("wr2_ferr",   ferr_a_n - s_ferr, 0);
      check("wr2_sdo",    rx, 32'h0);

      // Read reg2 back
      s_stb = stb_a_n;
      frame(32'h0200, 16, 1'b0, rx);
      check("rd2_sdo",    rx, 32'h0000_00A5);
      check("rd2_regs",   regs_a, 40'h00_00_A5_00_00);
      check("rd2_stb",    stb_a_n - s_stb, 0);

      // Write to out-of-range address 5, then read it
      s_stb = stb_a_n; s_ferr = ferr_a_n;
      frame(32'h8533, 16, 1'b0, rx);
      check("wr5_regs",   regs_a, 40'h00_00_A5_00_00);
      check("wr5_stb",    stb_a_n - s_stb, 0);
      check("wr5_ferr",   ferr_a_n - s_ferr, 0);
      frame(32'h0500, 16, 1'b0, rx);
      check("rd5_sdo",    rx, 32'h0);

      // Short (15-bit) and long (17-bit) frames
      s_stb = stb_a_n; s_ferr = ferr_a_n;
      frame(32'h40FF, 15, 1'b0, rx);
      check("short_ferr", ferr_a_n - s_ferr, 1);
      s_ferr = ferr_a_n;
      frame(32'h103FE, 17, 1'b0, rx);
      check("long_ferr",  ferr_a_n - s_ferr, 1);
      check("bad_stb",    stb_a_n - s_stb, 0);
      check("bad_regs",   regs_a, 40'h00_00_A5_00_00);

      // Reset mid-frame with cs held low, then finish the bits
      s_stb = stb_a_n; s_ferr = ferr_a_n;
      cs_down(1'b0);
      shift_bits(32'h83, 8, 1'b0, rx);
      @(negedge clk); rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_cs_low_sdo_en", sdo_en_a, 1'b0);
      shift_bits(32'hC3, 8, 1'b0, rx);
      cs_up(1'b0);
      check("abort_stb",  stb_a_n - s_stb, 0);
      check("abort_ferr", ferr_a_n - s_ferr, 0);
      check("abort_regs", regs_a, 40'h0);

      // Following full frame commits
      s_stb = stb_a_n;
      frame(32'h83C3, 16, 1'b0, rx);
      check("wr3_regs",   regs_a, 40'h00_C3_00_00_00);
      check("wr3_stb",    stb_a_n - s_stb, 1);
      check("wr3_addr",   wr_addr_a, 7'd3);

      // Alternate geometry: 20-bit frame to reg7
      s_stb = stb_b_n;
      frame(32'hF1234, 20, 1'b1, rx);
      check("b_wr7_regs", regs_b, {16'h1234, 112'h0});
      check("b_wr7_stb",  stb_b_n - s_stb, 1);
      check("b_wr7_addr", wr_addr_b, 3'd7);
      check("b_ferr",     ferr_b_n, 0);
      check("b_sdo",      rx, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
